// File: rtl/uart_pkg.sv
// Shared constants and types for the UART bit-timing strobe generator.
package uart_pkg;

    localparam int UART_DIV_WIDTH  = 16;
    localparam int UART_FRAC_WIDTH = 4;
    localparam int UART_OVERSAMPLE = 16;

    // Divisor as carried by the default-width configuration path.
    typedef struct packed {
        logic [UART_DIV_WIDTH-1:0]  div_int;
        logic [UART_FRAC_WIDTH-1:0] div_frac;
    } uart_div_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Configuration and strobe bundle between a UART core and the baud generator.
interface uart_baud_gen_if #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4
);
    logic [DIV_WIDTH-1:0]  i_divisor;
    logic [FRAC_WIDTH-1:0] i_div_frac;
    logic                  i_div_load;
    logic                  o_div_pending;
    logic                  i_tx_strb_en;
    logic                  o_tx_strb;
    logic                  i_rx_strb_en;
    logic                  o_rx_os_strb;
    logic                  o_rx_mid_strb;

    modport master (
        output i_divisor, i_div_frac, i_div_load, i_tx_strb_en, i_rx_strb_en,
        input  o_div_pending, o_tx_strb, o_rx_os_strb, o_rx_mid_strb
    );

    modport slave (
        input  i_divisor, i_div_frac, i_div_load, i_tx_strb_en, i_rx_strb_en,
        output o_div_pending, o_tx_strb, o_rx_os_strb, o_rx_mid_strb
    );
endinterface

// File: rtl/uart_frac_div.sv
// Fractional clock divider: emits a one-cycle base tick every Deff or Deff+1
// cycles so that N ticks span N*Deff + floor(N*F/2^FRAC_WIDTH) cycles.
module uart_frac_div #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DIV_WIDTH-1:0]  div_int,
    input  logic [FRAC_WIDTH-1:0] div_frac,
    output logic                  tick
);

    // One extra bit so a stretched period of 2^DIV_WIDTH cycles still fits.
    logic [DIV_WIDTH:0]    cnt;
    logic [DIV_WIDTH:0]    period_m1;
    logic [DIV_WIDTH-1:0]  d_eff;
    logic [FRAC_WIDTH-1:0] acc;
    logic [FRAC_WIDTH:0]   acc_sum;

    // Period of the current interval: stretched by one cycle whenever the
    // accumulation performed at its closing tick overflows.
    always_comb begin
        d_eff     = (div_int == '0) ? DIV_WIDTH'(1) : div_int;
        acc_sum   = {1'b0, acc} + {1'b0, div_frac};
        period_m1 = {1'b0, d_eff} - (DIV_WIDTH+1)'(1) + (DIV_WIDTH+1)'(acc_sum[FRAC_WIDTH]);
        tick      = en && (cnt == period_m1);
    end

    // Base counter and fractional accumulator; both held at zero while idle.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= '0;
            acc <= '0;
        end else if (tick) begin
            cnt <= '0;
            acc <= acc_sum[FRAC_WIDTH-1:0];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART bit-timing strobe generator: shadowed divisor, independent TX and RX
// fractional dividers, oversample counters and registered strobes.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH  = UART_DIV_WIDTH,
    parameter int FRAC_WIDTH = UART_FRAC_WIDTH,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_baud_gen_if.slave bus
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    typedef struct packed {
        logic [DIV_WIDTH-1:0]  div_int;
        logic [FRAC_WIDTH-1:0] div_frac;
    } div_cfg_t;

    localparam div_cfg_t DIV_RESET = '{div_int: DIV_WIDTH'(1), div_frac: FRAC_WIDTH'(0)};

    div_cfg_t        shadow;
    div_cfg_t        tx_act;
    div_cfg_t        rx_act;
    div_cfg_t        tx_use;
    div_cfg_t        rx_use;
    logic            tx_pend;
    logic            rx_pend;
    logic            tx_en_q;
    logic            rx_en_q;
    logic            tx_apply;
    logic            rx_apply;
    logic            tx_tick;
    logic            rx_tick;
    logic [OS_W-1:0] tx_os_cnt;
    logic [OS_W-1:0] rx_os_cnt;
    logic            tx_strb;
    logic            rx_os_strb;
    logic            rx_mid_strb;

    // A channel may take the shadow value while idle or in its first enabled
    // cycle (counters still at zero), so a rising enable sees the new divisor.
    always_comb begin
        tx_apply = tx_pend && (!bus.i_tx_strb_en || !tx_en_q);
        rx_apply = rx_pend && (!bus.i_rx_strb_en || !rx_en_q);
        tx_use   = tx_apply ? shadow : tx_act;
        rx_use   = rx_apply ? shadow : rx_act;
    end

    // Shadow divisor written by the load pulse.
    always_ff @(posedge clk) begin
        if (!rst_n)
            shadow <= DIV_RESET;
        else if (bus.i_div_load)
            shadow <= '{div_int: bus.i_divisor, div_frac: bus.i_div_frac};
    end

    // Per-channel active divisor and pending flag; a load in the apply cycle
    // keeps the flag set so the newer value is picked up afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_act  <= DIV_RESET;
            rx_act  <= DIV_RESET;
            tx_pend <= 1'b0;
            rx_pend <= 1'b0;
            tx_en_q <= 1'b0;
            rx_en_q <= 1'b0;
        end else begin
            tx_en_q <= bus.i_tx_strb_en;
            rx_en_q <= bus.i_rx_strb_en;
            if (tx_apply) begin
                tx_act  <= shadow;
                tx_pend <= 1'b0;
            end
            if (rx_apply) begin
                rx_act  <= shadow;
                rx_pend <= 1'b0;
            end
            if (bus.i_div_load) begin
                tx_pend <= 1'b1;
                rx_pend <= 1'b1;
            end
        end
    end

    uart_frac_div #(
        .DIV_WIDTH  (DIV_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_tx_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.i_tx_strb_en),
        .div_int  (tx_use.div_int),
        .div_frac (tx_use.div_frac),
        .tick     (tx_tick)
    );

    uart_frac_div #(
        .DIV_WIDTH  (DIV_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_rx_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.i_rx_strb_en),
        .div_int  (rx_use.div_int),
        .div_frac (rx_use.div_frac),
        .tick     (rx_tick)
    );

    // Oversample tick counters, cleared whenever their channel is idle.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.i_tx_strb_en)
            tx_os_cnt <= '0;
        else if (tx_tick)
            tx_os_cnt <= tx_os_cnt + 1'b1;

        if (!rst_n || !bus.i_rx_strb_en)
            rx_os_cnt <= '0;
        else if (rx_tick)
            rx_os_cnt <= rx_os_cnt + 1'b1;
    end

    // Registered strobes, one cycle after the tick that produces them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_strb     <= 1'b0;
            rx_os_strb  <= 1'b0;
            rx_mid_strb <= 1'b0;
        end else begin
            tx_strb     <= tx_tick && (tx_os_cnt == OS_LAST);
            rx_os_strb  <= rx_tick;
            rx_mid_strb <= rx_tick && (rx_os_cnt == OS_MID);
        end
    end

    assign bus.o_tx_strb     = tx_strb;
    assign bus.o_rx_os_strb  = rx_os_strb;
    assign bus.o_rx_mid_strb = rx_mid_strb;
    assign bus.o_div_pending = tx_pend | rx_pend;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: each enable window pushes the cycles at
// which strobes must appear; a negedge monitor pops and compares them.
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int FDEN = 1 << UART_FRAC_WIDTH;
    localparam int OS   = UART_OVERSAMPLE;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tx_q[$];
    int   os_q[$];
    int   mid_q[$];
    int   sh_d = 1;
    int   sh_f = 0;

    uart_baud_gen_if #(.DIV_WIDTH(UART_DIV_WIDTH), .FRAC_WIDTH(UART_FRAC_WIDTH)) bus ();

    uart_baud_gen #(
        .DIV_WIDTH  (UART_DIV_WIDTH),
        .FRAC_WIDTH (UART_FRAC_WIDTH),
        .OVERSAMPLE (UART_OVERSAMPLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: with Deff and F fixed, tick n (n >= 1) of a window starting in
    // cycle s falls in cycle s + n*Deff + floor(n*F/2^FRAC) - 1; strobes follow
    // one cycle later, only for ticks taken while the enable is still high.
    task automatic push_exp(input int s, input int tx_len, input int rx_len,
                            input int d_eff, input int f);
        int t;
        for (int n = 1; n < 100000; n++) begin
            t = s + n * d_eff + (n * f) / FDEN - 1;
            if (t >= s + tx_len) break;
            if (n % OS == 0) tx_q.push_back(t + 1);
        end
        for (int n = 1; n < 100000; n++) begin
            t = s + n * d_eff + (n * f) / FDEN - 1;
            if (t >= s + rx_len) break;
            os_q.push_back(t + 1);
            if (n % OS == OS / 2) mid_q.push_back(t + 1);
        end
    endtask

    // Monitor: missing strobes (expected cycle already passed) and every
    // presented strobe are compared against the queue heads.
    always @(negedge clk) begin
        if (tx_q.size() > 0 && tx_q[0] < cyc) chk("tx_strb_missing", cyc, tx_q.pop_front());
        if (os_q.size() > 0 && os_q[0] < cyc) chk("rx_os_missing", cyc, os_q.pop_front());
        if (mid_q.size() > 0 && mid_q[0] < cyc) chk("rx_mid_missing", cyc, mid_q.pop_front());
        if (bus.o_tx_strb) begin
            if (tx_q.size() == 0) chk("tx_strb_unexpected", cyc, -1);
            else chk("tx_strb_cycle", cyc, tx_q.pop_front());
        end
        if (bus.o_rx_os_strb) begin
            if (os_q.size() == 0) chk("rx_os_unexpected", cyc, -1);
            else chk("rx_os_cycle", cyc, os_q.pop_front());
        end
        if (bus.o_rx_mid_strb) begin
            if (mid_q.size() == 0) chk("rx_mid_unexpected", cyc, -1);
            else chk("rx_mid_cycle", cyc, mid_q.pop_front());
        end
    end

    // One enable window: both channels rise together, stay high for their own
    // lengths, then an idle gap. Optional divisor load at window cycle load_k,
    // optional one-cycle reset in the first cycle after both enables drop.
    task automatic window(input int tx_len, input int rx_len, input int load_k,
                          input int ld_d, input int ld_f, input int gap, input bit do_rst);
        int maxlen, total, s, d_eff;
        maxlen = (tx_len > rx_len) ? tx_len : rx_len;
        total  = ((load_k + 1 > maxlen) ? load_k + 1 : maxlen) + gap;
        d_eff  = (sh_d == 0) ? 1 : sh_d;
        s      = 0;
        for (int k = 0; k < total; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                s = cyc;
                push_exp(s, tx_len, rx_len, d_eff, sh_f);
            end
            bus.i_tx_strb_en = (k < tx_len);
            bus.i_rx_strb_en = (k < rx_len);
            bus.i_div_load   = (k == load_k);
            if (k == load_k) begin
                bus.i_divisor  = UART_DIV_WIDTH'(ld_d);
                bus.i_div_frac = UART_FRAC_WIDTH'(ld_f);
            end else begin
                bus.i_divisor  = UART_DIV_WIDTH'($urandom);
                bus.i_div_frac = UART_FRAC_WIDTH'($urandom);
            end
            rst_n = !(do_rst && k == maxlen);
            @(negedge clk);
            if (load_k >= 0 && k == load_k + 1)
                chk("pending_after_load", int'(bus.o_div_pending), 1);
            if (load_k >= 0 && k == load_k + 2 && k < tx_len)
                chk("pending_tx_busy", int'(bus.o_div_pending), 1);
            if (do_rst && k == maxlen + 1) begin
                chk("rst_tx_strb", int'(bus.o_tx_strb), 0);
                chk("rst_rx_os", int'(bus.o_rx_os_strb), 0);
                chk("rst_rx_mid", int'(bus.o_rx_mid_strb), 0);
                chk("rst_pending", int'(bus.o_div_pending), 0);
            end
            if (k == total - 1)
                chk("pending_cleared", int'(bus.o_div_pending), 0);
        end
        if (load_k >= 0) begin
            sh_d = ld_d;
            sh_f = ld_f;
        end
        if (do_rst) begin
            sh_d = 1;
            sh_f = 0;
        end
    endtask

    initial begin
        uart_div_t rv;
        int tl, rl, ml, lk;
        rst_n            = 1'b0;
        bus.i_divisor    = '0;
        bus.i_div_frac   = '0;
        bus.i_div_load   = 1'b0;
        bus.i_tx_strb_en = 1'b0;
        bus.i_rx_strb_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx_strb", int'(bus.o_tx_strb), 0);
        chk("reset_rx_os", int'(bus.o_rx_os_strb), 0);
        chk("reset_rx_mid", int'(bus.o_rx_mid_strb), 0);
        chk("reset_pending", int'(bus.o_div_pending), 0);

        // Divisor 1 straight out of reset: RX oversample every cycle.
        window(0, 40, -1, 0, 0, 2, 1'b0);
        // D=4 F=0: TX strobes at 64, 128, 192.
        window(0, 0, 0, 4, 0, 2, 1'b0);
        window(200, 0, -1, 0, 0, 2, 1'b0);
        // D=4 F=8: TX strobes at 72, 144.
        window(0, 0, 0, 4, 8, 2, 1'b0);
        window(150, 0, -1, 0, 0, 2, 1'b0);
        // D=0 clamps to 1: RX oversample every cycle, mid-bit at 8, 24, 40.
        window(0, 0, 0, 0, 0, 2, 1'b0);
        window(0, 41, -1, 0, 0, 2, 1'b0);
        // D=4, TX drop for 3 cycles then restart a full bit period.
        window(0, 0, 0, 4, 0, 2, 1'b0);
        window(40, 0, -1, 0, 0, 3, 1'b0);
        window(70, 0, -1, 0, 0, 2, 1'b0);
        // Load D=2 while TX runs on D=4; applied only after TX goes idle.
        window(70, 0, 10, 2, 0, 3, 1'b0);
        window(40, 0, -1, 0, 0, 2, 1'b0);
        // Reset mid-frame with a load outstanding; divisor falls back to 1.
        window(50, 50, 20, 5, 3, 3, 1'b1);
        window(40, 40, -1, 0, 0, 2, 1'b0);
        // Load coinciding with the rising enable keeps the old divisor.
        window(0, 0, 0, 3, 0, 2, 1'b0);
        window(60, 60, 0, 1, 5, 2, 1'b0);
        window(60, 60, -1, 0, 0, 2, 1'b0);

        for (int i = 0; i < 12; i++) begin
            tl = int'($urandom_range(180, 0));
            rl = int'($urandom_range(180, 0));
            ml = (tl > rl) ? tl : rl;
            rv.div_int  = UART_DIV_WIDTH'($urandom_range(5, 0));
            rv.div_frac = UART_FRAC_WIDTH'($urandom);
            lk = -1;
            if ($urandom_range(1, 0) == 1)
                lk = (ml > 0) ? int'($urandom_range(ml - 1, 0)) : 0;
            window(tl, rl, lk, int'(rv.div_int), int'(rv.div_frac),
                   int'($urandom_range(4, 2)), 1'b0);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("tx_queue_drained", tx_q.size(), 0);
        chk("rx_os_queue_drained", os_q.size(), 0);
        chk("rx_mid_queue_drained", mid_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Bit-timing strobe generator for the UART transmitter and receiver.
- Turns a programmable fractional divisor into a 16x oversample tick per channel.
- Drives the transmitter's per-bit strobe whenever the transmitter raises its strobe-enable.
- Drives the receiver's oversample and mid-bit sample strobes. Each channel has its own divider and restarts phase independently when its enable rises.

Parameters:
- DIV_WIDTH, 16, width of integer divisor (oversample period in clk cycles).
- FRAC_WIDTH, 4, width of fractional divisor part (units of 1/2^FRAC_WIDTH clk).
- OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_divisor  in  DIV_WIDTH  integer oversample period D.
- i_div_frac  in  FRAC_WIDTH  fractional period F.
- i_div_load  in  1  one-cycle pulse capturing i_divisor/i_div_frac into shadow registers.
- o_div_pending  out  1  shadow value not yet applied by at least one channel.
- i_tx_strb_en  in  1  transmitter requests bit strobes.
- o_tx_strb  out  1  one-cycle pulse at each TX bit boundary.
- i_rx_strb_en  in  1  receiver requests sampling (raised on start-bit edge).
- o_rx_os_strb  out  1  one-cycle pulse per RX oversample tick.
- o_rx_mid_strb  out  1  one-cycle pulse at RX mid-bit sample point.

Behaviour:
- Reset: all outputs 0; active and shadow divisors = 1, frac = 0; all counters and accumulators 0.
- Effective oversample period = Deff + F/2^FRAC_WIDTH cycles, where Deff = max(D, 1). D = 0 is clamped to 1.
- Fractional divider (per channel), enable low:
  - base counter, fractional accumulator and oversample counter held at 0.
  - no strobes.
- Fractional divider, enable high: base counter counts cycles.
  - A base tick occurs when the count reaches the current period minus 1; the counter then returns to 0.
  - On each tick, acc <= acc + F, truncated to FRAC_WIDTH bits.
  - A carry out makes the next period Deff+1 cycles; otherwise it is Deff.
- Timing reference: cycle 0 = first cycle enable is high. With F = 0, base ticks occur in cycles Deff-1, 2*Deff-1, and so on.
- TX channel:
  - An oversample counter counts base ticks modulo OVERSAMPLE.
  - o_tx_strb is registered. It pulses in the cycle after the tick that wraps the counter.
  - F = 0: pulses in cycles OVERSAMPLE*Deff, 2*OVERSAMPLE*Deff, and so on.
- RX channel:
  - o_rx_os_strb is the registered base tick, seen one cycle after each tick.
  - o_rx_mid_strb is registered. It pulses after tick number OVERSAMPLE/2, then every OVERSAMPLE ticks after that.
  - F = 0: pulses in cycles (OVERSAMPLE/2)*Deff, then +OVERSAMPLE*Deff each time.
- Enable deasserted mid-bit: counters clear in the next cycle. Any strobe already registered for that cycle still issues; no further strobes follow. Re-enabling restarts a full period from cycle 0.
- Enable held high across frames: counters free-run. There is no re-phasing.
- Divisor update:
  - i_div_load writes the shadow registers and sets per-channel pending flags.
  - Each channel copies shadow to active on the first cycle its enable is low, then clears its flag.
  - o_div_pending = OR of both flags.
  - A load while a channel is enabled never alters that channel's in-progress timing.
  - A load in the same cycle a flag would clear: the new value wins and the flag stays set.
- Enable rising in the same cycle as a pending apply: the channel starts with the new divisor.
- Reset mid-operation: everything returns to reset values next cycle; any shadow value is lost.

Decomposition:
- uart_pkg holds:
  - OVERSAMPLE default constant.
  - A typedef for divisor {int, frac} as a packed struct.
- One sub-module, uart_frac_div, instantiated twice (TX, RX). It contains:
  - enable, active divisor and frac inputs.
  - base counter and fractional accumulator.
  - a base-tick output.
- The top level contains the shadow/pending logic, the oversample counters and the output registers.

Test Plan:
- D=4, F=0, tx_en held high from cycle 0 -> o_tx_strb in cycles 64, 128, 192; exactly one cycle wide each.
- D=4, F=8, tx_en high -> period lengths alternate 4,5. o_tx_strb in cycles 72 and 144.
- D=0, F=0, rx_en high -> o_rx_os_strb every cycle from cycle 1; o_rx_mid_strb in cycles 8, 24, 40.
- D=4, tx_en high to cycle 40, low 3 cycles, high again at cycle 43 -> no strobe before cycle 43+64=107, strobe in cycle 107.
- tx_en high, i_div_load with D=2 at cycle 10 -> o_div_pending=1. Strobes stay on the D=4 grid. Drop tx_en -> channel applies D=2. Re-enable -> strobe 32 cycles later; pending clears once RX (idle) and TX have both applied.
- rst_n low for one cycle mid-frame -> all outputs 0 next cycle, o_div_pending=0, divisor back to 1.
